mux_8x1_rr_scheduler: RTL and testbench



---
 rtl/mux_8x1_rr_scheduler_if.sv | 31 +++
 rtl/mux_8x1_rr_scheduler.sv | 113 +++++++++++
 tb/tb_mux_8x1_rr_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_8x1_rr_scheduler_if.sv
// Bus between the requester front-ends and the 8:1 round-robin mux scheduler.
// Optional lock input exists only when MUX_SCHED_LOCK_EN is defined.
interface mux_8x1_rr_scheduler_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] din;
`ifdef MUX_SCHED_LOCK_EN
  logic       lock;
`endif
  logic [2:0] sel;
  logic [7:0] grant;
  logic       y;
  logic       busy;
  logic       slot_done;

  modport master (
    output en, req, din,
`ifdef MUX_SCHED_LOCK_EN
    output lock,
`endif
    input  sel, grant, y, busy, slot_done
  );

  modport slave (
    input  en, req, din,
`ifdef MUX_SCHED_LOCK_EN
    input  lock,
`endif
    output sel, grant, y, busy, slot_done
  );
endinterface

// File: rtl/mux_8x1_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// Define MUX_SCHED_LOCK_EN to add the lock input that holds a slot past SLOT_LEN.
module mux_8x1_rr_scheduler #(
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic                    clk,
  input logic                    rst,
  mux_8x1_rr_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_done_q, slot_done_d;

  logic [2:0]       pick;
  logic [2:0]       arb_ptr;
  logic             release_slot;
  logic             cnt_expired;

  // First set request bit scanning upward from p, wrapping modulo 8.
  function automatic logic [2:0] rr_pick(input logic [2:0] p, input logic [7:0] r);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef MUX_SCHED_LOCK_EN
  assign cnt_expired = (cnt_q == '0) && !(bus.lock && bus.req[sel_q]);
`else
  assign cnt_expired = (cnt_q == '0);
`endif

  assign release_slot = cnt_expired || !bus.req[sel_q];

  // On release the pointer advances first, so arbitration uses sel+1 this edge.
  assign arb_ptr = (state_q == HOLD) ? sel_q + 3'd1 : ptr_q;
  assign pick    = rr_pick(arb_ptr, bus.req);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    slot_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != '0)) begin
          state_d = HOLD;
          sel_d   = pick;
          grant_d = 8'(1) << pick;
          cnt_d   = CNT_W'(SLOT_LEN - 1);
        end
      end
      HOLD: begin
        if (release_slot) begin
          slot_done_d = 1'b1;
          ptr_d       = sel_q + 3'd1;
          if (bus.en && (bus.req != '0)) begin
            sel_d   = pick;
            grant_d = 8'(1) << pick;
            cnt_d   = CNT_W'(SLOT_LEN - 1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == HOLD);
  assign bus.slot_done = slot_done_q;
  assign bus.y         = (grant_q != '0) ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_8x1_rr_scheduler.sv
// Directed bench for mux_8x1_rr_scheduler; a second instance runs with SLOT_LEN=1.
module tb_mux_8x1_rr_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_8x1_rr_scheduler_if bus ();
  mux_8x1_rr_scheduler_if bus1 ();

  mux_8x1_rr_scheduler #(.SLOT_LEN(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mux_8x1_rr_scheduler #(.SLOT_LEN(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then inspected 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.req  = 8'hFF;
    bus.din  = 8'hFF;
    bus1.en  = 1'b0;
    bus1.req = 8'h00;
    bus1.din = 8'h00;
`ifdef MUX_SCHED_LOCK_EN
    bus.lock  = 1'b0;
    bus1.lock = 1'b0;
`endif
    step();
    step();
    chk("reset_grant", 32'(bus.grant), 32'h00);
    chk("reset_sel", 32'(bus.sel), 32'h0);
    chk("reset_y", 32'(bus.y), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_slot_done", 32'(bus.slot_done), 32'h0);
    rst = 1'b0;
    step();
    chk("first_grant", 32'(bus.grant), 32'h01);
    chk("first_sel", 32'(bus.sel), 32'h0);
    chk("first_busy", 32'(bus.busy), 32'h1);
  endtask

  // Continues directly from test_reset: grant 01 has just appeared.
  task automatic test_full_rotation();
    logic [7:0] pattern;
    pattern = 8'hA5;
    bus.din = pattern;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        chk("rot_grant", 32'(bus.grant), 32'(8'(1) << (g % 8)));
        chk("rot_sel", 32'(bus.sel), 32'(g % 8));
        chk("rot_slot_done", 32'(bus.slot_done), 32'((c == 0 && g > 0) ? 1 : 0));
        chk("rot_y", 32'(bus.y), 32'(pattern[g % 8]));
        step();
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'b0010_0100;
    step();
    chk("early_grant_c1", 32'(bus.grant), 32'h04);
    step();
    chk("early_grant_c2", 32'(bus.grant), 32'h04);
    bus.req = 8'b0010_0000;
    step();
    chk("skip_grant", 32'(bus.grant), 32'h20);
    chk("skip_sel", 32'(bus.sel), 32'h5);
    chk("skip_slot_done", 32'(bus.slot_done), 32'h1);
    chk("skip_busy", 32'(bus.busy), 32'h1);
    step();
    chk("skip_hold", 32'(bus.grant), 32'h20);
    chk("skip_pulse_end", 32'(bus.slot_done), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_grant", 32'(bus.grant), 32'h00);
    chk("midrst_slot_done", 32'(bus.slot_done), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_sel", 32'(bus.sel), 32'h0);
  endtask

  task automatic test_datapath();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h40;
    bus.din = 8'h00;
    step();
    chk("dp_grant", 32'(bus.grant), 32'h40);
    chk("dp_sel", 32'(bus.sel), 32'h6);
    bus.din = 8'b0100_0000;
    #1;
    chk("dp_y_one", 32'(bus.y), 32'h1);
    bus.din = 8'h00;
    #1;
    chk("dp_y_zero", 32'(bus.y), 32'h0);
    bus.req = 8'h00;
    step();
    chk("dp_idle_grant", 32'(bus.grant), 32'h00);
    chk("dp_idle_slot_done", 32'(bus.slot_done), 32'h1);
    chk("dp_idle_busy", 32'(bus.busy), 32'h0);
    chk("dp_idle_sel_hold", 32'(bus.sel), 32'h6);
    bus.din = 8'hFF;
    #1;
    chk("dp_idle_y", 32'(bus.y), 32'h0);
  endtask

  task automatic test_en_low_sole();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h08;
    step();
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk("sole_grant", 32'(bus.grant), 32'h08);
        chk("sole_slot_done", 32'(bus.slot_done), 32'((c == 0 && s > 0) ? 1 : 0));
        step();
      end
    end
    chk("sole_regrant_pulse", 32'(bus.slot_done), 32'h1);
    bus.en = 1'b0;
    for (int c = 1; c < 4; c++) begin
      step();
      chk("enlow_grant", 32'(bus.grant), 32'h08);
      chk("enlow_busy", 32'(bus.busy), 32'h1);
    end
    step();
    chk("enlow_end_grant", 32'(bus.grant), 32'h00);
    chk("enlow_end_slot_done", 32'(bus.slot_done), 32'h1);
    chk("enlow_end_busy", 32'(bus.busy), 32'h0);
    step();
    chk("enlow_no_grant", 32'(bus.grant), 32'h00);
    chk("enlow_pulse_end", 32'(bus.slot_done), 32'h0);
    bus.en = 1'b1;
  endtask

  task automatic test_slot_len1();
    do_reset();
    bus1.en  = 1'b1;
    bus1.req = 8'hFF;
    bus1.din = 8'h0F;
    for (int g = 0; g < 9; g++) begin
      step();
      chk("len1_grant", 32'(bus1.grant), 32'(8'(1) << (g % 8)));
      chk("len1_slot_done", 32'(bus1.slot_done), 32'((g > 0) ? 1 : 0));
      chk("len1_y", 32'(bus1.y), 32'((g % 8) < 4 ? 1 : 0));
    end
    bus1.en = 1'b0;
  endtask

`ifdef MUX_SCHED_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.en   = 1'b1;
    bus.req  = 8'h03;
    bus.lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("lock_grant", 32'(bus.grant), 32'h01);
      chk("lock_slot_done", 32'(bus.slot_done), 32'h0);
    end
    bus.lock = 1'b0;
    step();
    chk("unlock_grant", 32'(bus.grant), 32'h02);
    chk("unlock_slot_done", 32'(bus.slot_done), 32'h1);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_rotation();
    test_early_release();
    test_datapath();
    test_en_low_sole();
    test_slot_len1();
`ifdef MUX_SCHED_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
